prt_slot_scheduler: RTL and testbench
=====================================

// Module: prt_slot_scheduler
// PURPOSE
//  Controller that sequences the packet reference table (PRT): allocates a free slot per ingress frame,
//  drives start/stop_receive and byte writes, queues stored frames for the firewall verdict, then
//  schedules start_transmit for allowed frames and frees dropped/sent slots. Sits between ingress MAC and PRT.
// PARAMETERS
//  DATA_WIDTH   8     byte lane width of ingress/PRT data
//  NUM_ENTRIES  10    PRT slot count; SLOT_W = $clog2(NUM_ENTRIES)
//  FRAME_SIZE   1518  max bytes per frame; LEN_W = $clog2(FRAME_SIZE+1) = 11
// PORTS
//  clk                 in   1           system clock
//  rst                 in   1           reset: asynchronous assert, active-low
//  in_valid            in   1           ingress byte valid
//  in_data             in   DATA_WIDTH  ingress byte
//  in_last             in   1           last byte of frame
//  in_ready            out  1           ingress byte accepted when in_valid&in_ready
//  prt_slot_available  in   1           PRT has storage free
//  prt_start_receive   out  1           1-cycle pulse, opens slot prt_wr_slot
//  prt_stop_receive    out  1           1-cycle pulse, closes slot prt_wr_slot
//  prt_frame_in_valid  out  1           byte write strobe to PRT
//  prt_frame_data_in   out  DATA_WIDTH  byte to PRT
//  prt_wr_slot         out  SLOT_W      slot being written
//  prt_start_transmit  out  1           1-cycle pulse, starts readout of prt_rd_slot
//  prt_rd_slot         out  SLOT_W      slot being transmitted
//  prt_tx_done         in   1           PRT finished readout of prt_rd_slot
//  verdict_slot        out  SLOT_W      oldest stored slot awaiting verdict
//  verdict_ready       out  1           a slot awaits verdict
//  verdict_valid       in   1           verdict presented (consumed when verdict_ready)
//  verdict_allow       in   1           1 = transmit, 0 = drop
//  oversize            out  1           1-cycle pulse: frame exceeded FRAME_SIZE, discarded
// BEHAVIOUR
//  Reset: all outputs 0, free_mask all-ones, pend/tx FIFOs empty, both FSMs IDLE; mid-frame reset abandons frame.
//  Allocation: lowest-index set bit of free_mask; registered mask (same-cycle free not visible to alloc).
//  RX FSM: RX_IDLE -> RX_START when in_valid & prt_slot_available & |free_mask (else in_ready=0, wait).
//   RX_START: prt_start_receive=1, prt_wr_slot=alloc, clear bit; -> RX_DATA next cycle.
//   RX_DATA: in_ready=1; prt_frame_in_valid=in_valid, data passthrough combinational; byte count++.
//    accepted in_last -> RX_STOP. count==FRAME_SIZE and next byte not last -> RX_DRAIN, oversize pulse.
//   RX_STOP: prt_stop_receive=1, push slot to pend FIFO; -> RX_IDLE.
//   RX_DRAIN: in_ready=1, prt_frame_in_valid=0, discard until in_last; stop_receive pulse, slot freed,
//    not queued; -> RX_IDLE. 1-byte frame (last on first beat) is legal.
//  Verdict: pend FIFO (depth NUM_ENTRIES, arrival order); verdict_ready=!empty, verdict_slot=head.
//   valid&ready: pop; allow -> push tx FIFO; drop -> free slot same edge. valid with !ready ignored.
//  TX FSM: TX_IDLE -> TX_START when tx FIFO non-empty; TX_START: prt_start_transmit=1, prt_rd_slot=head,
//   pop; -> TX_WAIT; TX_WAIT until prt_tx_done, then free slot -> TX_IDLE. One transmit in flight.
//  Simultaneous drop-free and tx-free: both bits set same edge. FIFOs cannot overflow (<= NUM_ENTRIES slots).
//  Latency: start_receive 1 cycle after in_valid seen in IDLE; first byte accepted cycle after.
// CONFIGURATION
//  PRT_STATS_EN defined: adds outputs stat_rx, stat_tx, stat_drop, stat_oversize (32b each, saturating,
//   reset 0; increment on RX_STOP, tx_done, drop verdict, oversize pulse). Undefined: ports and logic absent.
// STRUCTURE
//  prt_pkg: rx_state_t {RX_IDLE,RX_START,RX_DATA,RX_STOP,RX_DRAIN}, tx_state_t {TX_IDLE,TX_START,TX_WAIT},
//   SLOT_W/LEN_W helper functions. Sub-module: prt_slot_fifo (parameterised slot-id FIFO), used twice.
// TESTING
//  Frame AA,BB,CC,DD,EE(last) -> start_receive slot0, 5 write strobes, stop_receive, verdict_slot=0.
//  Allow verdict for slot0 -> start_transmit rd_slot=0; tx_done -> slot0 free, next frame reuses slot0.
//  Three frames, verdicts drop/allow/allow -> slot0 freed no tx; transmits slot1 then slot2 in order.
//  10 frames held without verdict -> in_ready stays 0 with in_valid on 11th; first drop frees slot, 11th proceeds.
//  1519-byte frame -> oversize pulse after byte 1518, no pend entry, slot freed; next frame gets slot0.
//  Reset asserted in RX_DATA -> outputs 0 immediately, all slots free after release; PRT_STATS_EN counters 0.

Source files
------------

// File: rtl/prt_pkg.sv
// prt_pkg: shared types and sizing helpers for the PRT slot scheduler.
//   rx_state_t - ingress sequencing states
//   tx_state_t - egress sequencing states
//   slot_w()   - slot-id width for a given slot count (never below 1)
//   len_w()    - byte-counter width able to hold the value FRAME_SIZE
package prt_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_DRAIN
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_WAIT
  } tx_state_t;

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int len_w(input int fs);
    return $clog2(fs + 1);
  endfunction

endpackage

// File: rtl/prt_slot_fifo.sv
// prt_slot_fifo: small circular FIFO of slot ids.
//   clk, rst        clock, asynchronous active-low reset
//   push, push_slot write a slot id (dropped if full, cannot happen in use)
//   pop             remove head (ignored when empty)
//   head            current head entry (valid when !empty)
//   empty           no entries stored
// Storage is reset so head never carries X into downstream muxes.
module prt_slot_fifo
  import prt_pkg::*;
#(
  parameter int DEPTH = 10,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_slot,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty
);

  localparam int PW = slot_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           rd_ptr, wr_ptr;
  logic [CW-1:0]           count;
  logic                    full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_slot;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/prt_slot_scheduler.sv
// prt_slot_scheduler: sequences the packet reference table (PRT).
// Allocates a free slot per ingress frame, streams its bytes into the PRT,
// queues stored slots for a firewall verdict, then transmits allowed slots
// one at a time and returns dropped / sent / oversize slots to the pool.
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_data/in_last      ingress byte stream, in_ready handshake
//   prt_slot_available            PRT storage free
//   prt_start_receive/stop_receive  1-cycle open/close pulses for prt_wr_slot
//   prt_frame_in_valid/data_in    byte write strobe and data into the PRT
//   prt_start_transmit/prt_rd_slot  1-cycle readout start for prt_rd_slot
//   prt_tx_done                   PRT finished reading prt_rd_slot
//   verdict_ready/verdict_slot    oldest stored slot awaiting a verdict
//   verdict_valid/verdict_allow   verdict (1 = transmit, 0 = drop)
//   oversize                      1-cycle pulse, frame exceeded FRAME_SIZE
// Build option
//   PRT_STATS_EN  adds saturating 32-bit counters stat_rx, stat_tx,
//                 stat_drop, stat_oversize. Absent when undefined.
module prt_slot_scheduler
  import prt_pkg::*;
#(
  parameter int  DATA_WIDTH  = 8,
  parameter int  NUM_ENTRIES = 10,
  parameter int  FRAME_SIZE  = 1518,
  localparam int SLOT_W      = slot_w(NUM_ENTRIES),
  localparam int LEN_W       = len_w(FRAME_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  prt_slot_available,
  output logic                  prt_start_receive,
  output logic                  prt_stop_receive,
  output logic                  prt_frame_in_valid,
  output logic [DATA_WIDTH-1:0] prt_frame_data_in,
  output logic [SLOT_W-1:0]     prt_wr_slot,
  output logic                  prt_start_transmit,
  output logic [SLOT_W-1:0]     prt_rd_slot,
  input  logic                  prt_tx_done,
  output logic [SLOT_W-1:0]     verdict_slot,
  output logic                  verdict_ready,
  input  logic                  verdict_valid,
  input  logic                  verdict_allow,
`ifdef PRT_STATS_EN
  output logic [31:0]           stat_rx,
  output logic [31:0]           stat_tx,
  output logic [31:0]           stat_drop,
  output logic [31:0]           stat_oversize,
`endif
  output logic                  oversize
);

  rx_state_t               rx_state;
  tx_state_t               tx_state;
  logic [NUM_ENTRIES-1:0]  free_mask, free_set, free_clr;
  logic [SLOT_W-1:0]       alloc_slot;
  logic [LEN_W-1:0]        byte_cnt;
  logic [SLOT_W-1:0]       pend_head, tx_head;
  logic                    pend_empty, tx_empty;
  logic                    pend_push, pend_pop, tx_push, tx_pop;
  logic                    rx_accept, rx_go, at_limit;
  logic                    drop, tx_free, drain_free;

  // Lowest free slot; scanning downward lets the lowest index win.
  always_comb begin
    alloc_slot = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (free_mask[i]) alloc_slot = SLOT_W'(i);
  end

  assign in_ready           = (rx_state == RX_DATA) || (rx_state == RX_DRAIN);
  assign rx_accept          = in_valid && in_ready;
  assign prt_frame_in_valid = (rx_state == RX_DATA) && in_valid;
  // Gated so the PRT data bus stays quiet outside a write window.
  assign prt_frame_data_in  = (rx_state == RX_DATA) ? in_data : '0;
  assign rx_go              = (rx_state == RX_IDLE) && in_valid &&
                              prt_slot_available && (|free_mask);
  // Byte being accepted is number FRAME_SIZE; if it is not last, the frame overflows.
  assign at_limit           = (byte_cnt == LEN_W'(FRAME_SIZE - 1));

  assign pend_push  = (rx_state == RX_STOP);
  assign pend_pop   = verdict_valid && !pend_empty;
  assign tx_push    = pend_pop && verdict_allow;
  assign drop       = pend_pop && !verdict_allow;
  assign tx_pop     = (tx_state == TX_IDLE) && !tx_empty;
  assign tx_free    = (tx_state == TX_WAIT) && prt_tx_done;
  assign drain_free = (rx_state == RX_DRAIN) && rx_accept && in_last;

  assign verdict_ready = !pend_empty;
  assign verdict_slot  = pend_empty ? '0 : pend_head;

  // Release sources touch distinct allocated slots, so OR-ing them is safe;
  // the claimed slot is always a free one, so set and clear never collide.
  always_comb begin
    free_set = '0;
    free_clr = '0;
    if (drop)       free_set[pend_head]   = 1'b1;
    if (tx_free)    free_set[prt_rd_slot] = 1'b1;
    if (drain_free) free_set[prt_wr_slot] = 1'b1;
    if (rx_go)      free_clr[alloc_slot]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) free_mask <= '1;
    else      free_mask <= (free_mask & ~free_clr) | free_set;
  end

  // Ingress sequencer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state          <= RX_IDLE;
      prt_wr_slot       <= '0;
      byte_cnt          <= '0;
      prt_start_receive <= 1'b0;
      prt_stop_receive  <= 1'b0;
      oversize          <= 1'b0;
    end else begin
      prt_start_receive <= 1'b0;
      prt_stop_receive  <= 1'b0;
      oversize          <= 1'b0;
      case (rx_state)
        RX_IDLE: if (rx_go) begin
          rx_state          <= RX_START;
          prt_start_receive <= 1'b1;
          prt_wr_slot       <= alloc_slot;
          byte_cnt          <= '0;
        end
        RX_START: rx_state <= RX_DATA;
        RX_DATA: if (rx_accept) begin
          byte_cnt <= byte_cnt + 1'b1;
          if (in_last) begin
            rx_state         <= RX_STOP;
            prt_stop_receive <= 1'b1;
          end else if (at_limit) begin
            rx_state <= RX_DRAIN;
            oversize <= 1'b1;
          end
        end
        RX_STOP: rx_state <= RX_IDLE;
        RX_DRAIN: if (rx_accept && in_last) begin
          rx_state         <= RX_IDLE;
          prt_stop_receive <= 1'b1;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // Egress sequencer: one readout in flight at a time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state           <= TX_IDLE;
      prt_start_transmit <= 1'b0;
      prt_rd_slot        <= '0;
    end else begin
      prt_start_transmit <= 1'b0;
      case (tx_state)
        TX_IDLE: if (!tx_empty) begin
          tx_state           <= TX_START;
          prt_start_transmit <= 1'b1;
          prt_rd_slot        <= tx_head;
        end
        TX_START: tx_state <= TX_WAIT;
        TX_WAIT:  if (prt_tx_done) tx_state <= TX_IDLE;
        default:  tx_state <= TX_IDLE;
      endcase
    end
  end

  // Slots waiting for a verdict, in arrival order.
  prt_slot_fifo #(.DEPTH(NUM_ENTRIES), .W(SLOT_W)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .push      (pend_push),
    .push_slot (prt_wr_slot),
    .pop       (pend_pop),
    .head      (pend_head),
    .empty     (pend_empty)
  );

  // Allowed slots waiting for transmit.
  prt_slot_fifo #(.DEPTH(NUM_ENTRIES), .W(SLOT_W)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_slot (pend_head),
    .pop       (tx_pop),
    .head      (tx_head),
    .empty     (tx_empty)
  );

`ifdef PRT_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_rx       <= '0;
      stat_tx       <= '0;
      stat_drop     <= '0;
      stat_oversize <= '0;
    end else begin
      if (rx_state == RX_STOP && stat_rx != '1)  stat_rx       <= stat_rx + 1'b1;
      if (tx_free && stat_tx != '1)              stat_tx       <= stat_tx + 1'b1;
      if (drop && stat_drop != '1)               stat_drop     <= stat_drop + 1'b1;
      if (oversize && stat_oversize != '1)       stat_oversize <= stat_oversize + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_prt_slot_scheduler.sv
// tb_prt_slot_scheduler: directed bench for prt_slot_scheduler.
// A cycle table covers one full frame lifecycle, then hand-written
// sequences cover slot reuse, verdict ordering, pool exhaustion,
// the FRAME_SIZE boundary and reset in mid-frame.
module tb_prt_slot_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 0, in_last = 0, prt_slot_available = 0;
  logic [7:0] in_data = '0;
  logic       prt_tx_done = 0, verdict_valid = 0, verdict_allow = 0;
  logic       in_ready, prt_start_receive, prt_stop_receive, prt_frame_in_valid;
  logic [7:0] prt_frame_data_in;
  logic [3:0] prt_wr_slot, prt_rd_slot, verdict_slot;
  logic       prt_start_transmit, verdict_ready, oversize;
`ifdef PRT_STATS_EN
  logic [31:0] stat_rx, stat_tx, stat_drop, stat_oversize;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prt_slot_scheduler dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .prt_slot_available (prt_slot_available),
    .prt_start_receive  (prt_start_receive),
    .prt_stop_receive   (prt_stop_receive),
    .prt_frame_in_valid (prt_frame_in_valid),
    .prt_frame_data_in  (prt_frame_data_in),
    .prt_wr_slot        (prt_wr_slot),
    .prt_start_transmit (prt_start_transmit),
    .prt_rd_slot        (prt_rd_slot),
    .prt_tx_done        (prt_tx_done),
    .verdict_slot       (verdict_slot),
    .verdict_ready      (verdict_ready),
    .verdict_valid      (verdict_valid),
    .verdict_allow      (verdict_allow),
`ifdef PRT_STATS_EN
    .stat_rx            (stat_rx),
    .stat_tx            (stat_tx),
    .stat_drop          (stat_drop),
    .stat_oversize      (stat_oversize),
`endif
    .oversize           (oversize)
  );

  // Event monitor, sampled on the falling edge.
  int         n_start = 0, n_stop = 0, n_over = 0, n_wr = 0, n_served = 0;
  logic [3:0] last_wr = '0;
  logic [3:0] tx_log[$];

  always @(negedge clk) begin
    if (prt_start_receive) begin n_start++; last_wr = prt_wr_slot; end
    if (prt_stop_receive) n_stop++;
    if (oversize) n_over++;
    if (prt_frame_in_valid) n_wr++;
    if (prt_start_transmit) tx_log.push_back(prt_rd_slot);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic iv; logic [7:0] d; logic il; logic av; logic vv; logic va; logic td;
    logic rdy; logic sr; logic sp; logic fiv; logic [7:0] fd; logic [3:0] ws;
    logic st; logic [3:0] rs; logic vr; logic [3:0] vs;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic il,
                              input logic vv, input logic va, input logic td,
                              input logic rdy, input logic sr, input logic sp,
                              input logic fiv, input logic [7:0] fd, input logic st,
                              input logic vr);
    vec_t v;
    v.iv = iv; v.d = d; v.il = il; v.av = 1'b1; v.vv = vv; v.va = va; v.td = td;
    v.rdy = rdy; v.sr = sr; v.sp = sp; v.fiv = fiv; v.fd = fd; v.ws = 4'd0;
    v.st = st; v.rs = 4'd0; v.vr = vr; v.vs = 4'd0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 0; in_last = 0; in_data = '0;
    verdict_valid = 0; verdict_allow = 0; prt_tx_done = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    prt_slot_available = 1'b1;
  endtask

  // Called at a drive point (1 ns after a rising edge); returns at one.
  task automatic send_frame(input int n, input logic [7:0] seed);
    int i = 0;
    int g = 0;
    while (i < n && g < 4000) begin
      in_valid = 1'b1;
      in_data  = 8'(seed + i);
      in_last  = (i == n - 1);
      #1;
      if (in_ready) i++;
      @(posedge clk); #1;
      g++;
    end
    in_valid = 0; in_last = 0; in_data = '0;
    chk("frame_bytes_accepted", i, n);
  endtask

  task automatic verdict(input logic allow, input logic [3:0] exp_slot);
    int g = 0;
    while (!verdict_ready && g < 50) begin @(posedge clk); #1; g++; end
    chk("verdict_ready", verdict_ready, 1);
    chk("verdict_slot", verdict_slot, exp_slot);
    verdict_valid = 1'b1; verdict_allow = allow;
    @(posedge clk); #1;
    verdict_valid = 0; verdict_allow = 0;
  endtask

  task automatic serve_tx();
    int g = 0;
    while (tx_log.size() <= n_served && g < 50) begin @(posedge clk); #1; g++; end
    chk("tx_started", tx_log.size() > n_served, 1);
    n_served++;
    prt_tx_done = 1'b1;
    @(posedge clk); #1;
    prt_tx_done = 1'b0;
  endtask

  vec_t tv[18];
  logic [25:0] act_v, exp_v;
  int s0, o0, w0, g;
  logic seen;

  initial begin
    // iv  d      il  vv va td | rdy sr sp fiv fd     st vr
    tv[0]  = mk(1, 8'hAA, 0, 0, 0, 0,  0, 0, 0, 0, 8'h00, 0, 0);
    tv[1]  = mk(1, 8'hAA, 0, 0, 0, 0,  0, 1, 0, 0, 8'h00, 0, 0);
    tv[2]  = mk(1, 8'hAA, 0, 0, 0, 0,  1, 0, 0, 1, 8'hAA, 0, 0);
    tv[3]  = mk(1, 8'hBB, 0, 0, 0, 0,  1, 0, 0, 1, 8'hBB, 0, 0);
    tv[4]  = mk(1, 8'hCC, 0, 0, 0, 0,  1, 0, 0, 1, 8'hCC, 0, 0);
    tv[5]  = mk(1, 8'hDD, 0, 0, 0, 0,  1, 0, 0, 1, 8'hDD, 0, 0);
    tv[6]  = mk(1, 8'hEE, 1, 0, 0, 0,  1, 0, 0, 1, 8'hEE, 0, 0);
    tv[7]  = mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0, 0);
    tv[8]  = mk(0, 8'h00, 0, 1, 1, 0,  0, 0, 0, 0, 8'h00, 0, 1);
    tv[9]  = mk(0, 8'h00, 0, 1, 1, 0,  0, 0, 0, 0, 8'h00, 0, 0); // not ready: ignored
    tv[10] = mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 8'h00, 1, 0);
    tv[11] = mk(0, 8'h00, 0, 0, 0, 1,  0, 0, 0, 0, 8'h00, 0, 0);
    tv[12] = mk(1, 8'hFF, 1, 0, 0, 0,  0, 0, 0, 0, 8'h00, 0, 0);
    tv[13] = mk(1, 8'hFF, 1, 0, 0, 0,  0, 1, 0, 0, 8'h00, 0, 0); // slot0 reused
    tv[14] = mk(1, 8'hFF, 1, 0, 0, 0,  1, 0, 0, 1, 8'hFF, 0, 0);
    tv[15] = mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 1, 0, 8'h00, 0, 0);
    tv[16] = mk(0, 8'h00, 0, 1, 0, 0,  0, 0, 0, 0, 8'h00, 0, 1);
    tv[17] = mk(0, 8'h00, 0, 0, 0, 0,  0, 0, 0, 0, 8'h00, 0, 0);

    // Reset state
    #3;
    chk("reset_outputs",
        {in_ready, prt_start_receive, prt_stop_receive, prt_frame_in_valid,
         prt_frame_data_in, prt_wr_slot, prt_start_transmit, prt_rd_slot,
         verdict_ready, verdict_slot, oversize}, 0);
    do_reset();

    // Single-frame lifecycle table
    for (int i = 0; i < 18; i++) begin
      in_valid = tv[i].iv; in_data = tv[i].d; in_last = tv[i].il;
      prt_slot_available = tv[i].av; verdict_valid = tv[i].vv;
      verdict_allow = tv[i].va; prt_tx_done = tv[i].td;
      #1;
      act_v = {in_ready, prt_start_receive, prt_stop_receive, prt_frame_in_valid,
               prt_frame_data_in, prt_wr_slot, prt_start_transmit, prt_rd_slot,
               verdict_ready, verdict_slot};
      exp_v = {tv[i].rdy, tv[i].sr, tv[i].sp, tv[i].fiv, tv[i].fd, tv[i].ws,
               tv[i].st, tv[i].rs, tv[i].vr, tv[i].vs};
      chk($sformatf("vec%0d", i), act_v, exp_v);
      @(posedge clk); #1;
    end
    in_valid = 0; in_last = 0; verdict_valid = 0; verdict_allow = 0; prt_tx_done = 0;

    // Drop / allow / allow: dropped slot returns to pool, transmits in order
    tx_log.delete(); n_served = 0;
    send_frame(3, 8'h10);
    chk("alloc_a", last_wr, 0);
    send_frame(3, 8'h20);
    chk("alloc_b", last_wr, 1);
    send_frame(3, 8'h30);
    chk("alloc_c", last_wr, 2);
    verdict(1'b0, 4'd0);
    send_frame(2, 8'h40);
    chk("alloc_after_drop", last_wr, 0);
    verdict(1'b1, 4'd1);
    verdict(1'b1, 4'd2);
    serve_tx();
    serve_tx();
    verdict(1'b0, 4'd0);
    repeat (4) @(posedge clk); #1;
    chk("tx_count", tx_log.size(), 2);
    if (tx_log.size() == 2) begin
      chk("tx_first_slot", tx_log[0], 1);
      chk("tx_second_slot", tx_log[1], 2);
    end

    // Pool exhaustion: 10 held frames block the 11th until a drop
    do_reset();
    for (int k = 0; k < 10; k++) send_frame(2, 8'(k * 16));
    chk("alloc_tenth", last_wr, 9);
    s0 = n_start; seen = 0;
    in_valid = 1; in_data = 8'h77; in_last = 1;
    for (int k = 0; k < 8; k++) begin
      #1; seen = seen | in_ready;
      @(posedge clk); #1;
    end
    chk("full_in_ready_low", seen, 0);
    chk("full_no_start", n_start - s0, 0);
    verdict(1'b0, 4'd0);
    send_frame(1, 8'h77);
    chk("eleventh_started", n_start - s0, 1);
    chk("eleventh_slot", last_wr, 0);

    // FRAME_SIZE boundary
    do_reset();
    o0 = n_over; w0 = n_wr;
    send_frame(1518, 8'h00);
    repeat (3) @(posedge clk); #1;
    chk("max_frame_no_oversize", n_over - o0, 0);
    chk("max_frame_writes", n_wr - w0, 1518);
    verdict(1'b0, 4'd0);
    o0 = n_over; w0 = n_wr; s0 = n_stop;
    send_frame(1519, 8'h00);
    repeat (3) @(posedge clk); #1;
    chk("oversize_pulse_cycles", n_over - o0, 1);
    chk("oversize_writes", n_wr - w0, 1518);
    chk("oversize_stop", n_stop - s0, 1);
    chk("oversize_not_queued", verdict_ready, 0);
    send_frame(1, 8'h55);
    chk("after_oversize_slot", last_wr, 0);

    // Reset while in RX_DATA
    do_reset();
    send_frame(2, 8'h20);
    in_valid = 1; in_data = 8'h11; in_last = 0;
    g = 0;
    #1;
    while (!in_ready && g < 20) begin @(posedge clk); #2; g++; end
    @(posedge clk); #1;
    chk("mid_pre_in_ready", in_ready, 1);
    chk("mid_pre_wr_slot", prt_wr_slot, 1);
    #1 rst = 1'b0;
    #1;
    chk("mid_reset_outputs",
        {in_ready, prt_start_receive, prt_stop_receive, prt_frame_in_valid,
         prt_frame_data_in, prt_wr_slot, prt_start_transmit, prt_rd_slot,
         verdict_ready, verdict_slot, oversize}, 0);
`ifdef PRT_STATS_EN
    chk("mid_reset_stats", {stat_rx, stat_tx, stat_drop, stat_oversize}, 0);
`endif
    in_valid = 0; in_last = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_no_verdict", verdict_ready, 0);
    send_frame(1, 8'h30);
    chk("post_reset_slot_a", last_wr, 0);
    send_frame(1, 8'h31);
    chk("post_reset_slot_b", last_wr, 1);
    verdict(1'b0, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
